gpio_event_monitor: RTL and testbench

//  N-channel GPIO drive/monitor agent for the frigate bench and bring-up logic; generalises single-pad drive/monitor taps.
//  Per channel: registered pad drive with enable, synchronised level monitor, rise/fall edge detection.

---
 rtl/gpio_event_monitor.sv | 149 ++++++++++++++
 tb/tb_gpio_event_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_event_monitor.sv
// N-channel GPIO drive/monitor agent: registered pad drive, synchronised level
// monitor, per-channel edge capture and a timestamped show-ahead event FIFO.
module gpio_event_monitor #(
   parameter int NUM_CH      = 8,
   parameter int TS_W        = 16,
   parameter int DEPTH       = 16,
   parameter int SYNC_STAGES = 2,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_CH-1:0] drv_en,
   input  logic [NUM_CH-1:0] drv_val,
   output logic [NUM_CH-1:0] pad_oe,
   output logic [NUM_CH-1:0] pad_out,
   input  logic [NUM_CH-1:0] pad_in,
   input  logic [NUM_CH-1:0] rise_mask,
   input  logic [NUM_CH-1:0] fall_mask,
   output logic [NUM_CH-1:0] mon_level,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [CH_W-1:0]   evt_ch,
   output logic              evt_level,
   output logic [TS_W-1:0]   evt_ts,
   output logic [CNT_W-1:0]  evt_count,
   output logic              overflow,
   input  logic              overflow_clr
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [NUM_CH-1:0] sync_p [SYNC_STAGES];
   logic [NUM_CH-1:0] new_level;
   logic [NUM_CH-1:0] edge_hit;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] grant;
   logic [NUM_CH-1:0] pend_level;
   logic [TS_W-1:0]   pend_ts [NUM_CH];
   logic [TS_W-1:0]   ts;

   logic [CH_W-1:0]   mem_ch [DEPTH];
   logic [DEPTH-1:0]  mem_level;
   logic [TS_W-1:0]   mem_ts [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   logic [CH_W-1:0]   wr_ch;
   logic              wr_en;
   logic              writable;
   logic              pop;
   logic              lost;

   // Pad drive: one register stage, no gating
   always_ff @(posedge clock) begin
      if (reset) begin
         pad_oe  <= '0;
         pad_out <= '0;
      end else begin
         pad_oe  <= drv_en;
         pad_out <= drv_val;
      end
   end

   // Input synchroniser chain; last stage is the monitored level
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
      end else begin
         sync_p[0] <= pad_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
      end
   end

   assign mon_level = sync_p[SYNC_STAGES-1];
   assign new_level = sync_p[SYNC_STAGES-2];

   always_ff @(posedge clock) begin
      if (reset) ts <= '0;
      else       ts <= ts + 1'b1;
   end

   // Edge detect looks one stage ahead so the pending capture lands on the
   // same clock edge at which mon_level changes.
   assign edge_hit = (new_level & ~mon_level & rise_mask)
                   | (~new_level & mon_level & fall_mask);

   // Arbiter: lowest-index pending channel wins the single write slot
   always_comb begin
      wr_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pending[i]) wr_ch = CH_W'(i);
      end
   end

   assign pop      = evt_valid & evt_ready;
   assign writable = (evt_count < CNT_W'(DEPTH)) | pop;
   assign wr_en    = (|pending) & writable;
   assign grant    = wr_en ? (NUM_CH'(1) << wr_ch) : '0;
   assign lost     = |(edge_hit & pending & ~grant);

   // Pending slots: a fresh edge always overwrites, so the latest level wins
   always_ff @(posedge clock) begin
      if (reset) pending <= '0;
      else       pending <= (pending & ~grant) | edge_hit;
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (edge_hit[i]) begin
            pend_level[i] <= new_level[i];
            pend_ts[i]    <= ts;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset)        overflow <= 1'b0;
      else if (lost)    overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
   end

   // Event FIFO: storage is not reset, heads are masked while empty
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         evt_count <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         evt_count <= evt_count + CNT_W'(wr_en) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_ch[wr_ptr]    <= wr_ch;
         mem_level[wr_ptr] <= pend_level[wr_ch];
         mem_ts[wr_ptr]    <= pend_ts[wr_ch];
      end
   end

   assign evt_valid = (evt_count != '0);
   assign evt_ch    = evt_valid ? mem_ch[rd_ptr]    : '0;
   assign evt_level = evt_valid ? mem_level[rd_ptr] : 1'b0;
   assign evt_ts    = evt_valid ? mem_ts[rd_ptr]    : '0;

endmodule

// File: tb/tb_gpio_event_monitor.sv
// Scoreboard bench for gpio_event_monitor: expected events queued as pad
// edges are driven, compared as the consumer pops them.
module tb_gpio_event_monitor;
   localparam int NUM_CH = 8;
   localparam int TS_W   = 16;
   localparam int DEPTH  = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  drv_en, drv_val, pad_oe, pad_out, pad_in;
   logic [7:0]  rise_mask, fall_mask, mon_level;
   logic        evt_valid, evt_ready, evt_level, overflow, overflow_clr;
   logic [2:0]  evt_ch;
   logic [15:0] evt_ts;
   logic [4:0]  evt_count;

   typedef struct packed {
      logic [2:0]  ch;
      logic        level;
      logic [15:0] ts;
   } ev_t;

   ev_t         sb[$];
   logic [15:0] ts_m;
   int          checks   = 0;
   int          failures = 0;
   int          n_post;

   gpio_event_monitor #(
      .NUM_CH(NUM_CH), .TS_W(TS_W), .DEPTH(DEPTH), .SYNC_STAGES(2)
   ) dut (
      .clock(clock), .reset(reset),
      .drv_en(drv_en), .drv_val(drv_val), .pad_oe(pad_oe), .pad_out(pad_out),
      .pad_in(pad_in), .rise_mask(rise_mask), .fall_mask(fall_mask),
      .mon_level(mon_level), .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_ch(evt_ch), .evt_level(evt_level), .evt_ts(evt_ts),
      .evt_count(evt_count), .overflow(overflow), .overflow_clr(overflow_clr)
   );

   always #5 clock = ~clock;

   // Reference free-running timestamp
   always @(posedge clock) ts_m <= reset ? 16'd0 : ts_m + 16'd1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Flip one pad; queue the expected event if the edge is masked in and kept
   task automatic toggle(input int ch, input bit keep);
      ev_t e;
      pad_in[ch] = ~pad_in[ch];
      if (keep && (pad_in[ch] ? rise_mask[ch] : fall_mask[ch])) begin
         e.ch    = 3'(ch);
         e.level = pad_in[ch];
         e.ts    = ts_m + 16'd1;
         sb.push_back(e);
      end
   endtask

   task automatic pop_chk(input string tag);
      ev_t e;
      check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check({tag, "_vld"}, evt_valid, 1);
      check({tag, "_ch"}, evt_ch, e.ch);
      check({tag, "_lvl"}, evt_level, e.level);
      check({tag, "_ts"}, evt_ts, e.ts);
      evt_ready = 1'b1;
      cycles(1);
      evt_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; drv_en = '0; drv_val = '0; pad_in = '0;
      rise_mask = '1; fall_mask = '1; evt_ready = 1'b0; overflow_clr = 1'b0;
      cycles(3);
      check("rst_oe", pad_oe, 0);
      check("rst_out", pad_out, 0);
      check("rst_mon", mon_level, 0);
      check("rst_vld", evt_valid, 0);
      check("rst_cnt", evt_count, 0);
      check("rst_ovf", overflow, 0);
      check("rst_ch", evt_ch, 0);
      check("rst_lvl", evt_level, 0);
      check("rst_ts", evt_ts, 0);
      reset = 1'b0;
      cycles(2);

      // T1: single rise, latency and head contents
      toggle(3, 1);
      cycles(2);
      check("t1_early", evt_valid, 0);
      cycles(1);
      check("t1_valid", evt_valid, 1);
      check("t1_mon", mon_level[3], 1);
      pop_chk("t1");

      // T2: simultaneous rises, lowest channel first, equal timestamps
      toggle(0, 1);
      toggle(5, 1);
      cycles(4);
      check("t2_count", evt_count, 2);
      pop_chk("t2a");
      pop_chk("t2b");

      // T3: fill FIFO, 17th edge held pending until a pop frees a slot
      for (int j = 0; j < 17; j++) begin
         toggle(j % 8, 1);
         cycles(1);
      end
      cycles(4);
      check("t3_count", evt_count, 16);
      check("t3_ovf", overflow, 0);
      pop_chk("t3_pop");
      check("t3_refill", evt_count, 16);

      // T4: second edge on a stalled pending channel -> overflow, latest wins
      toggle(2, 0);
      cycles(3);
      check("t4_no_ovf", overflow, 0);
      toggle(2, 1);
      cycles(3);
      check("t4_ovf", overflow, 1);
      while (sb.size() > 0) pop_chk("t4_drain");
      check("t4_empty", evt_count, 0);
      check("t4_sticky", overflow, 1);
      overflow_clr = 1'b1;
      cycles(1);
      overflow_clr = 1'b0;
      check("t4_clr", overflow, 0);

      // Ready while empty must not disturb the FIFO
      evt_ready = 1'b1;
      cycles(2);
      evt_ready = 1'b0;
      check("idle_rdy_cnt", evt_count, 0);
      check("idle_rdy_vld", evt_valid, 0);

      // T5: fall masked off on ch1
      toggle(1, 1);
      cycles(4);
      pop_chk("t5_rise0");
      fall_mask[1] = 1'b0;
      toggle(1, 1);
      cycles(4);
      check("t5_nofall", evt_count, 0);
      toggle(1, 1);
      cycles(4);
      check("t5_count", evt_count, 1);
      pop_chk("t5_rise");
      fall_mask[1] = 1'b1;

      // T6: drive path then reset mid-burst
      drv_en = 8'h81;
      drv_val = 8'h01;
      check("t6_oe_hold", pad_oe, 0);
      cycles(1);
      check("t6_oe", pad_oe, 8'h81);
      check("t6_out", pad_out, 8'h01);
      toggle(4, 0);
      toggle(6, 0);
      cycles(1);
      toggle(7, 0);
      cycles(3);
      check("t6_busy", evt_count != 0, 1);
      reset = 1'b1;
      cycles(1);
      check("t6_rst_vld", evt_valid, 0);
      check("t6_rst_cnt", evt_count, 0);
      check("t6_rst_oe", pad_oe, 0);
      check("t6_rst_mon", mon_level, 0);
      sb.delete();
      reset = 1'b0;
      n_post = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pad_in[i] && rise_mask[i]) begin
            sb.push_back('{ch: 3'(i), level: 1'b1, ts: ts_m + 16'd1});
            n_post++;
         end
      end
      cycles(NUM_CH + 3);
      check("t6_post_cnt", evt_count, n_post);
      while (sb.size() > 0) pop_chk("t6_post");
      check("t6_post_empty", evt_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
